// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - default operand/result width
//   - ALU opcode constants
//   - arbiter FSM state encoding
//   - helper that classifies an opcode as legal or illegal
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

   localparam int W_DEFAULT = 16;

   localparam logic [2:0] OP_PASS   = 3'd1;
   localparam logic [2:0] OP_ADD    = 3'd2;
   localparam logic [2:0] OP_SUB    = 3'd3;
   localparam logic [2:0] OP_LSHIFT = 3'd4;
   localparam logic [2:0] OP_RSHIFT = 3'd6;

   // Value driven on alu_op while nothing legal is in flight.
   localparam logic [2:0] OP_IDLE   = 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op == OP_PASS) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_LSHIFT) || (op == OP_RSHIFT);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker (purely combinational).
//   req  [1:0] : request vector
//   last       : index of the requester served most recently
//   win  [1:0] : one-hot winner, all zero when nobody requests
// A lone request always wins; on a tie the requester that was not served
// last wins.
// ---------------------------------------------------------------------------
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters.
//   clk, rst          : clock, synchronous active-high reset
//   req0/op0/a0/b0    : requester 0 request, opcode and operands
//   req1/op1/a1/b1    : requester 1 request, opcode and operands
//   gnt  [1:0]        : one-hot grant pulse (operands captured that cycle)
//   done [1:0]        : one-hot completion pulse to the served requester
//   res, res_z, err   : result, zero flag and illegal-op flag of the last
//                       completed request (held until the next completion)
//   busy              : high whenever the FSM is outside IDLE
//   alu_a/alu_b/alu_op: registered operands/opcode to the shared ALU
//   alu_c/alu_z       : ALU result/zero flag, valid one clk after issue
// Legal op timeline:  IDLE(gnt) -> ISSUE -> WAIT(capture) -> DONE(done)
// Illegal op timeline: IDLE(gnt) -> DONE(done), ALU never sees the op.
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [2:0]   op0,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic         req1,
   input  logic [2:0]   op1,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic [1:0]   gnt,
   output logic [1:0]   done,
   output logic [W-1:0] res,
   output logic         res_z,
   output logic         err,
   output logic         busy,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_op,
   input  logic [W-1:0] alu_c,
   input  logic         alu_z
);

   state_t         state_reg, state_next;
   logic           last_reg;     // index of requester served last
   logic           served_reg;   // index of requester currently in flight
   logic [1:0]     done_reg;
   logic [W-1:0]   res_reg;
   logic           res_z_reg;
   logic           err_reg;
   logic [W-1:0]   alu_a_reg;
   logic [W-1:0]   alu_b_reg;
   logic [2:0]     alu_op_reg;

   logic [1:0]     win;
   logic [2:0]     win_op;
   logic [W-1:0]   win_a;
   logic [W-1:0]   win_b;
   logic           win_legal;
   logic           in_idle;

   rr_pick2 u_pick (
      .req  ({req1, req0}),
      .last (last_reg),
      .win  (win)
   );

   // Winner's request fields, only meaningful when win is non-zero.
   always_comb begin
      win_op    = win[1] ? op1 : op0;
      win_a     = win[1] ? a1  : a0;
      win_b     = win[1] ? b1  : b0;
      win_legal = is_legal_op(win_op);
   end

   assign in_idle = (state_reg == ST_IDLE);

   // Requests are only looked at in IDLE, so the grant is the picker output
   // gated by the state.
   assign gnt    = in_idle ? win : 2'b00;
   assign busy   = ~in_idle;
   assign done   = done_reg;
   assign res    = res_reg;
   assign res_z  = res_z_reg;
   assign err    = err_reg;
   assign alu_a  = alu_a_reg;
   assign alu_b  = alu_b_reg;
   assign alu_op = alu_op_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (win != 2'b00) begin
               state_next = win_legal ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT:  state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         last_reg   <= 1'b1;        // pretend requester 1 went last: favour 0
         served_reg <= 1'b0;
         done_reg   <= 2'b00;
         res_reg    <= '0;
         res_z_reg  <= 1'b0;
         err_reg    <= 1'b0;
         alu_a_reg  <= '0;
         alu_b_reg  <= '0;
         alu_op_reg <= OP_IDLE;
      end else begin
         state_reg <= state_next;
         done_reg  <= 2'b00;
         case (state_reg)
            ST_IDLE: begin
               if (win != 2'b00) begin
                  last_reg   <= win[1];
                  served_reg <= win[1];
                  if (win_legal) begin
                     alu_a_reg  <= win_a;
                     alu_b_reg  <= win_b;
                     alu_op_reg <= win_op;
                  end else begin
                     // Illegal op completes directly without touching
                     // the ALU; the flags become visible in DONE.
                     res_reg   <= '0;
                     res_z_reg <= 1'b1;
                     err_reg   <= 1'b1;
                     done_reg  <= win;
                  end
               end
            end
            ST_WAIT: begin
               res_reg    <= alu_c;
               res_z_reg  <= alu_z;
               err_reg    <= 1'b0;
               alu_op_reg <= OP_IDLE;
               done_reg   <= served_reg ? 2'b10 : 2'b01;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a transaction-level reference model
// (cycles-since-grant timeline) checked every cycle, plus literal
// expectations for each directed scenario. Also provides the external ALU.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1;
   logic [2:0]   op0, op1;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   gnt, done;
   logic [W-1:0] res;
   logic         res_z, err, busy;
   logic [W-1:0] alu_a, alu_b;
   logic [2:0]   alu_op;
   logic [W-1:0] alu_c = '0;
   logic         alu_z = 1'b0;

   int checks   = 0;
   int failures = 0;

   alu_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1),
      .gnt(gnt), .done(done), .res(res), .res_z(res_z), .err(err),
      .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_c(alu_c), .alu_z(alu_z)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [2:0]   op);
      case (op)
         3'd1:    return a;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a << b;
         3'd6:    return a >> b;
         default: return '0;
      endcase
   endfunction

   // External ALU: result one clock after operands are applied.
   always @(posedge clk) begin
      alu_c <= alu_f(alu_a, alu_b, alu_op);
      alu_z <= (alu_f(alu_a, alu_b, alu_op) == '0);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // m_k = cycles since grant (0 = idle); m_doneat = cycle of the done pulse.
   bit           m_en = 0;
   int           m_k = 0, m_doneat = 0, m_srv = 0, m_last = 1;
   bit           m_legal = 0;
   logic [2:0]   m_op = '0;
   logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
   logic         m_z = 0, m_err = 0;

   initial begin
      logic [1:0] e_gnt, e_done;
      logic [2:0] e_op;
      forever begin
         @(negedge clk);
         if (m_en) begin
            e_gnt  = 2'b00;
            e_done = 2'b00;
            e_op   = 3'd0;
            if (m_k == 0) begin
               if (req0 && req1) e_gnt = (m_last == 0) ? 2'b10 : 2'b01;
               else              e_gnt = {req1, req0};
            end else begin
               if (m_k == m_doneat) e_done = (m_srv == 1) ? 2'b10 : 2'b01;
               if (m_legal && m_k < 3) e_op = m_op;
            end
            chk("m_gnt",   gnt,    e_gnt);
            chk("m_done",  done,   e_done);
            chk("m_busy",  busy,   m_k != 0);
            chk("m_res",   res,    m_res);
            chk("m_res_z", res_z,  m_z);
            chk("m_err",   err,    m_err);
            chk("m_alu_op", alu_op, e_op);
            if (m_legal && (m_k == 1 || m_k == 2)) begin
               chk("m_alu_a", alu_a, m_a);
               chk("m_alu_b", alu_b, m_b);
            end
            // advance across the coming rising edge
            if (rst) begin
               m_k = 0; m_last = 1; m_res = '0; m_z = 0; m_err = 0; m_legal = 0;
            end else if (m_k == 0) begin
               if (e_gnt != 2'b00) begin
                  m_srv   = e_gnt[1] ? 1 : 0;
                  m_last  = m_srv;
                  m_op    = e_gnt[1] ? op1 : op0;
                  m_a     = e_gnt[1] ? a1 : a0;
                  m_b     = e_gnt[1] ? b1 : b0;
                  m_legal = (m_op == 1) || (m_op == 2) || (m_op == 3) ||
                            (m_op == 4) || (m_op == 6);
                  if (m_legal) m_doneat = 3;
                  else begin
                     m_doneat = 1; m_res = '0; m_z = 1; m_err = 1;
                  end
                  m_k = 1;
               end
            end else if (m_k == m_doneat) begin
               m_k = 0;
            end else begin
               if (m_k == 2) begin
                  m_res = alu_f(m_a, m_b, m_op);
                  m_z   = (m_res == '0);
                  m_err = 0;
               end
               m_k++;
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   // Returns at the negedge of the grant cycle; reports cycles waited.
   task automatic wait_gnt(input logic [1:0] exp, input int exp_wait,
                           input string name);
      int got = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin got = n; break; end
      end
      chk({name, "_gnt"}, gnt, exp);
      if (exp_wait > 0) chk({name, "_gnt_wait"}, got, exp_wait);
      else if (got == 0) chk({name, "_gnt_timeout"}, 0, 1);
   endtask

   // Called right after the grant cycle's edge; counts cycles to done.
   task automatic wait_done(input logic [1:0] exp_done, input int exp_lat,
                            input logic [W-1:0] exp_res, input logic exp_z,
                            input logic exp_err, input string name);
      int got = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (done != 2'b00) begin got = n; break; end
      end
      chk({name, "_lat"},   got,  exp_lat);
      chk({name, "_done"},  done, exp_done);
      chk({name, "_res"},   res,  exp_res);
      chk({name, "_res_z"}, res_z, exp_z);
      chk({name, "_err"},   err,  exp_err);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; req0 = 0; req1 = 0;
      op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      @(posedge clk); #1 m_en = 1;
      @(posedge clk); #1 rst = 0;

      // reset state
      @(negedge clk);
      chk("rst_gnt", gnt, 2'b00);   chk("rst_done", done, 2'b00);
      chk("rst_busy", busy, 1'b0);  chk("rst_err", err, 1'b0);
      chk("rst_res", res, 16'd0);   chk("rst_res_z", res_z, 1'b0);
      chk("rst_alu_op", alu_op, 3'd0);
      chk("rst_alu_a", alu_a, 16'd0); chk("rst_alu_b", alu_b, 16'd0);

      // 1: req0 ADD 2+4
      @(posedge clk); #1 req0 = 1; op0 = 3'd2; a0 = 16'd2; b0 = 16'd4;
      wait_gnt(2'b01, 1, "s1");
      @(posedge clk); #1 req0 = 0; op0 = 3'd7; a0 = 16'hffff;
      wait_done(2'b01, 3, 16'd6, 1'b0, 1'b0, "s1");

      // 2: req1 SUB 4-4
      @(posedge clk); #1 req1 = 1; op1 = 3'd3; a1 = 16'd4; b1 = 16'd4;
      wait_gnt(2'b10, 1, "s2");
      @(posedge clk); #1 req1 = 0;
      wait_done(2'b10, 3, 16'd0, 1'b1, 1'b0, "s2");

      // 3: tie from reset, req1 held across req0's service
      do_reset();
      @(posedge clk); #1
      req0 = 1; op0 = 3'd1; a0 = 16'd2;  b0 = 16'd9;
      req1 = 1; op1 = 3'd6; a1 = 16'd20; b1 = 16'd4;
      wait_gnt(2'b01, 1, "s3a");
      @(posedge clk); #1 req0 = 0;
      wait_done(2'b01, 3, 16'd2, 1'b0, 1'b0, "s3a");
      chk("s3_busy_in_done", busy, 1'b1);
      wait_gnt(2'b10, 1, "s3b");
      @(posedge clk); #1 req1 = 0;
      wait_done(2'b10, 3, 16'd1, 1'b0, 1'b0, "s3b");

      // 4: illegal opcode 5
      @(posedge clk); #1 req0 = 1; op0 = 3'd5; a0 = 16'd3; b0 = 16'd3;
      wait_gnt(2'b01, 1, "s4");
      @(posedge clk); #1 req0 = 0;
      wait_done(2'b01, 1, 16'd0, 1'b1, 1'b1, "s4");
      chk("s4_alu_op", alu_op, 3'd0);
      @(negedge clk);
      chk("s4_hold_err", err, 1'b1);
      chk("s4_idle_busy", busy, 1'b0);

      // 5: reset during WAIT aborts the op
      @(posedge clk); #1 req0 = 1; op0 = 3'd3; a0 = 16'd9; b0 = 16'd1;
      wait_gnt(2'b01, 1, "s5");
      @(posedge clk); #1 req0 = 0;          // now in ISSUE
      @(posedge clk); #1 rst = 1;           // now in WAIT
      @(negedge clk);
      chk("s5_wait_busy", busy, 1'b1);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("s5_busy_after_rst", busy, 1'b0);
      chk("s5_no_done", done, 2'b00);
      chk("s5_err_cleared", err, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s5_still_no_done", done, 2'b00);
      end
      @(posedge clk); #1 req0 = 1; op0 = 3'd4; a0 = 16'd1; b0 = 16'd4;
      wait_gnt(2'b01, 1, "s5b");
      @(posedge clk); #1 req0 = 0;
      wait_done(2'b01, 3, 16'd16, 1'b0, 1'b0, "s5b");

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
